// File: rtl/load_store_unit_if.sv
// Core-request / response handshake plus word-wide data-memory bus for the LSU.
interface load_store_unit_if;
  // core request
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  // response to core
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  // data memory
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  // the LSU itself
  modport master (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_read, mem_write, mem_addr, mem_wdata
  );

  // core + memory side
  modport slave (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one request at a time, word-wide memory accesses,
// sub-word stores by read-modify-write, registered response handshake.
module load_store_unit #(
  parameter int DEPTH_WORDS = 1024,
  parameter bit WORD_ADDR   = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  load_store_unit_if.master bus
);
  typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, RESP} state_t;

  localparam logic [31:0] DEPTH_L = DEPTH_WORDS;

  state_t      state_q, state_d;
  logic [31:0] addr_q, wdata_q;
  logic [2:0]  f3_q;
  logic        we_q;

  logic        req_ready_q, resp_valid_q, resp_err_q;
  logic [31:0] resp_rdata_q;
  logic        mem_read_q, mem_write_q;
  logic [31:0] mem_addr_q, mem_wdata_q;

  logic        accept, req_err;
  logic [31:0] cur_addr, cur_maddr, ld_ext, merged, wr_word;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;

  assign accept = bus.req_valid & req_ready_q;

  // Request legality, evaluated on the live request at acceptance
  always_comb begin
    req_err = 1'b0;
    if (!(bus.req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) req_err = 1'b1;
    if (bus.req_we && bus.req_funct3[2])                                 req_err = 1'b1;
    if (bus.req_funct3 == 3'b001 && bus.req_addr[0])                     req_err = 1'b1;
    if (bus.req_funct3 == 3'b010 && bus.req_addr[1:0] != 2'b00)          req_err = 1'b1;
    if ({2'b00, bus.req_addr[31:2]} >= DEPTH_L)                          req_err = 1'b1;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) begin
        if (req_err)                       state_d = RESP;
        else if (!bus.req_we)              state_d = LOAD;
        else if (bus.req_funct3 == 3'b010) state_d = WRITE;
        else                               state_d = RMW_RD;
      end
      LOAD:    state_d = RESP;
      RMW_RD:  state_d = WRITE;
      WRITE:   state_d = RESP;
      RESP:    if (bus.resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Load extraction and store merge; the address comes live from the
  // request while still in IDLE so SW can issue its write the next cycle.
  always_comb begin
    cur_addr  = (state_q == IDLE) ? bus.req_addr : addr_q;
    cur_maddr = WORD_ADDR ? {2'b00, cur_addr[31:2]} : {cur_addr[31:2], 2'b00};
    ld_b      = bus.mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    ld_h      = bus.mem_rdata[{addr_q[1], 4'b0000} +: 16];
    case (f3_q)
      3'b000:  ld_ext = {{24{ld_b[7]}}, ld_b};
      3'b001:  ld_ext = {{16{ld_h[15]}}, ld_h};
      3'b100:  ld_ext = {24'h0, ld_b};
      3'b101:  ld_ext = {16'h0, ld_h};
      default: ld_ext = bus.mem_rdata;
    endcase
    merged = bus.mem_rdata;
    if (f3_q[1:0] == 2'b00) merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    else                    merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    wr_word = (state_q == IDLE) ? bus.req_wdata : merged;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Request capture at acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0; wdata_q <= '0; f3_q <= '0; we_q <= 1'b0;
    end else if (state_q == IDLE && accept) begin
      addr_q <= bus.req_addr; wdata_q <= bus.req_wdata;
      f3_q <= bus.req_funct3; we_q <= bus.req_we;
    end
  end

  // Registered outputs, derived from the state being entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      req_ready_q <= (state_d == IDLE);
      mem_read_q  <= (state_d == LOAD) || (state_d == RMW_RD);
      mem_write_q <= (state_d == WRITE);
      mem_addr_q  <= (state_d inside {LOAD, RMW_RD, WRITE}) ? cur_maddr : 32'h0;
      mem_wdata_q <= (state_d == WRITE) ? wr_word : 32'h0;
      if (state_d == RESP && state_q != RESP) begin
        resp_valid_q <= 1'b1;
        resp_err_q   <= (state_q == IDLE);  // only errors jump IDLE -> RESP
        resp_rdata_q <= (state_q == LOAD) ? ld_ext : 32'h0;
      end else if (state_d != RESP) begin
        resp_valid_q <= 1'b0;
        resp_err_q   <= 1'b0;
        resp_rdata_q <= '0;
      end
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.mem_read   = mem_read_q;
  assign bus.mem_write  = mem_write_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;

  logic unused_we;
  assign unused_we = we_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: request-level reference model plus a
// per-cycle compare process, with literal pins on key results.
module tb_load_store_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  load_store_unit_if bus ();
  load_store_unit #(.DEPTH_WORDS(1024), .WORD_ADDR(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  // data memory seen by the DUT
  logic [31:0] mem [0:1023];
  always @(posedge clk) if (bus.mem_write) mem[bus.mem_addr[9:0]] <= bus.mem_wdata;
  assign bus.mem_rdata = bus.mem_read ? mem[bus.mem_addr[9:0]] : 32'h0;

  int n_cmp = 0, n_bad = 0;
  task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model state and current expectations
  logic [31:0] refm [0:1023];
  bit          e_err;
  logic [31:0] e_rdata, e_wdata, e_maddr;
  int          e_lat, e_nrd, e_nwr;

  task automatic model(input bit we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
    logic [31:0] w, v;
    logic [63:0] mask;
    int n, sh;
    e_err = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) || (we && f3[2]) ||
            (f3 == 3'd1 && addr[0]) || (f3 == 3'd2 && addr[1:0] != 2'b00) || ((addr >> 2) >= 1024);
    e_maddr = addr >> 2; e_rdata = 0; e_wdata = 0; e_nrd = 0; e_nwr = 0; e_lat = 1;
    if (!e_err) begin
      w  = refm[addr >> 2];
      n  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      sh = 8 * int'(addr % 4);
      if (!we) begin
        e_lat = 2; e_nrd = 1; v = w >> sh;
        case (f3)
          3'd0:    e_rdata = ((v & 32'hFF) ^ 32'h80) - 32'h80;
          3'd4:    e_rdata = v & 32'hFF;
          3'd1:    e_rdata = ((v & 32'hFFFF) ^ 32'h8000) - 32'h8000;
          3'd5:    e_rdata = v & 32'hFFFF;
          default: e_rdata = w;
        endcase
      end else begin
        mask    = ((64'd1 << (8 * n)) - 64'd1) << sh;
        e_wdata = (w & ~mask[31:0]) | ((wd << sh) & mask[31:0]);
        e_nwr   = 1;
        e_nrd   = (n == 4) ? 0 : 1;
        e_lat   = (n == 4) ? 2 : 3;
        refm[addr >> 2] = e_wdata;
      end
    end
  endtask

  // per-cycle compare against the current expectation
  bit active = 1'b0;
  int t, nrd, nwr, stray = 0;
  always @(negedge clk) begin
    if (!active && bus.mem_write) stray++;
    if (active) begin
      t++;
      chk(!(bus.mem_read && bus.mem_write), "rd_wr_excl", {bus.mem_read, bus.mem_write}, 0);
      chk(bus.req_ready == 1'b0, "busy_ready", bus.req_ready, 0);
      if (bus.mem_read) begin
        nrd++; chk(bus.mem_addr == e_maddr, "rd_addr", bus.mem_addr, e_maddr);
      end
      if (bus.mem_write) begin
        nwr++;
        chk(bus.mem_addr == e_maddr, "wr_addr", bus.mem_addr, e_maddr);
        chk(bus.mem_wdata == e_wdata, "wr_data", bus.mem_wdata, e_wdata);
      end
      if (t < e_lat) chk(bus.resp_valid == 1'b0, "early_valid", bus.resp_valid, 0);
      else begin
        chk(bus.resp_valid == 1'b1, "resp_valid", bus.resp_valid, 1);
        chk(bus.resp_err == e_err, "resp_err", bus.resp_err, e_err);
        chk(bus.resp_rdata == e_rdata, "resp_rdata", bus.resp_rdata, e_rdata);
        chk(!bus.mem_read && !bus.mem_write && bus.mem_addr == 0, "resp_mem_idle", bus.mem_addr, 0);
      end
    end
  end

  logic [31:0] last_rdata;
  task automatic do_req(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input int stall);
    int n = 0;
    while (!bus.req_ready && n < 10) begin @(posedge clk); #1; n++; end
    chk(bus.req_ready == 1'b1, "ready_wait", bus.req_ready, 1);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
    bus.req_addr = addr; bus.req_wdata = wd;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    model(we, f3, addr, wd);
    t = 0; nrd = 0; nwr = 0; active = 1'b1;
    n = 0;
    while (!bus.resp_valid && n < 10) begin @(posedge clk); #1; n++; end
    chk(bus.resp_valid == 1'b1, "resp_timeout", bus.resp_valid, 1);
    repeat (stall) begin @(posedge clk); #1; end
    last_rdata = bus.resp_rdata;
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0; active = 1'b0;
    chk(nrd == e_nrd, "read_count", nrd, e_nrd);
    chk(nwr == e_nwr, "write_count", nwr, e_nwr);
    chk(bus.req_ready == 1'b1, "ready_after", bus.req_ready, 1);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) refm[i] = 32'h0;
    bus.req_valid = 0; bus.req_we = 0; bus.req_funct3 = 0;
    bus.req_addr = 0; bus.req_wdata = 0; bus.resp_ready = 0;
    #12;
    chk(bus.req_ready == 0, "rst_req_ready", bus.req_ready, 0);
    chk(bus.resp_valid == 0 && bus.resp_err == 0, "rst_resp", bus.resp_valid, 0);
    chk(bus.resp_rdata == 0, "rst_rdata", bus.resp_rdata, 0);
    chk(!bus.mem_read && !bus.mem_write && bus.mem_addr == 0 && bus.mem_wdata == 0,
        "rst_mem", bus.mem_addr, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk(bus.req_ready == 1, "ready_after_rst", bus.req_ready, 1);

    // word store / load
    do_req(1, 3'b010, 32'h10, 32'hDEADBEEF, 0);
    chk(mem[4] == 32'hDEADBEEF, "pin_sw_mem", mem[4], 32'hDEADBEEF);
    do_req(0, 3'b010, 32'h10, 0, 0);
    chk(last_rdata == 32'hDEADBEEF, "pin_lw", last_rdata, 32'hDEADBEEF);

    // byte read-modify-write and byte loads
    do_req(1, 3'b010, 32'h10, 32'h11223344, 0);
    do_req(1, 3'b000, 32'h12, 32'h000000AA, 0);
    chk(mem[4] == 32'h11AA3344, "pin_sb_mem", mem[4], 32'h11AA3344);
    do_req(0, 3'b000, 32'h12, 0, 0);
    chk(last_rdata == 32'hFFFFFFAA, "pin_lb", last_rdata, 32'hFFFFFFAA);
    do_req(0, 3'b100, 32'h12, 0, 0);
    chk(last_rdata == 32'h000000AA, "pin_lbu", last_rdata, 32'h000000AA);
    do_req(0, 3'b000, 32'h13, 0, 0);
    chk(last_rdata == 32'h00000011, "pin_lb3", last_rdata, 32'h00000011);
    do_req(0, 3'b000, 32'h10, 0, 0);

    // halfword store and loads
    do_req(1, 3'b010, 32'h14, 32'h11223344, 0);
    do_req(1, 3'b001, 32'h16, 32'h00008001, 0);
    chk(mem[5] == 32'h80013344, "pin_sh_mem", mem[5], 32'h80013344);
    do_req(0, 3'b001, 32'h16, 0, 0);
    chk(last_rdata == 32'hFFFF8001, "pin_lh", last_rdata, 32'hFFFF8001);
    do_req(0, 3'b101, 32'h16, 0, 0);
    chk(last_rdata == 32'h00008001, "pin_lhu", last_rdata, 32'h00008001);
    do_req(0, 3'b101, 32'h14, 0, 0);

    // errors
    do_req(0, 3'b010, 32'h11,   0, 0);
    do_req(1, 3'b001, 32'h13,   32'h1234, 0);
    do_req(0, 3'b011, 32'h10,   0, 0);
    do_req(1, 3'b100, 32'h10,   32'h55, 0);
    do_req(0, 3'b010, 32'h1000, 0, 0);
    chk(last_rdata == 32'h0, "pin_err_rdata", last_rdata, 0);
    chk(mem[4] == 32'h11AA3344, "err_no_write", mem[4], 32'h11AA3344);

    // response backpressure
    do_req(0, 3'b010, 32'h10, 0, 5);
    chk(last_rdata == 32'h11AA3344, "pin_bp_lw", last_rdata, 32'h11AA3344);

    // reset in the middle of an SB read-modify-write
    bus.req_valid = 1; bus.req_we = 1; bus.req_funct3 = 3'b000;
    bus.req_addr = 32'h11; bus.req_wdata = 32'h55;
    @(posedge clk); #1;
    bus.req_valid = 0;
    chk(bus.mem_read == 1, "rmw_read", bus.mem_read, 1);
    #2 rst_n = 1'b0;
    #1;
    chk(!bus.mem_read && !bus.mem_write, "rst_mid_mem", {bus.mem_read, bus.mem_write}, 0);
    chk(bus.mem_addr == 0 && bus.resp_valid == 0 && bus.req_ready == 0, "rst_mid_out", bus.mem_addr, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk(bus.req_ready == 1, "ready_after_mid_rst", bus.req_ready, 1);
    repeat (2) @(posedge clk); #1;
    chk(stray == 0, "no_stray_write", stray, 0);
    chk(mem[4] == 32'h11AA3344, "rst_mem_unchanged", mem[4], 32'h11AA3344);
    do_req(0, 3'b010, 32'h10, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory interface, sitting between the core's MEM stage and data_memory.
- Accepts one RV32I load/store request at a time (LB/LH/LW/LBU/LHU/SB/SH/SW) and checks alignment and range.
- Drives word-wide mem_read/mem_write accesses. Sub-word stores use read-modify-write, because the memory only writes full words.
- Returns the extended load data, or an error flag, through a valid/ready response handshake.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the memory. Word index >= DEPTH_WORDS is an out-of-range error.
- WORD_ADDR, 1, selects the mem_addr format. 1: mem_addr is the word index, {2'b00, addr[31:2]}. 0: mem_addr is the byte address with bits [1:0] forced to 0.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  32  byte address
- req_wdata  in  32  store data, LSB-aligned
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts response
- resp_rdata  out  32  load result (0 for stores and errors)
- resp_err  out  1  misaligned, out-of-range or illegal funct3
- mem_read  out  1  memory read enable
- mem_write  out  1  memory write enable (sampled by memory at posedge)
- mem_addr  out  32  memory address per WORD_ADDR
- mem_wdata  out  32  full word to write
- mem_rdata  in  32  combinational read data, valid in the same cycle mem_read=1

Behaviour:
- Reset (async, rst_n=0) forces state IDLE and sets every output register to 0. This takes effect immediately, including mid-operation: mem_read, mem_write and resp_valid drop at once, and any pending store is abandoned with no write.
- Reset output values: req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, mem_*=0. req_ready rises in the first cycle after rst_n deasserts.
- req_ready = (state==IDLE). A request is accepted when req_valid & req_ready. On acceptance, addr, funct3, we and wdata are registered.
- Error check at acceptance; any error goes straight to RESP with resp_err=1 and no mem_read or mem_write is ever asserted. Error conditions:
  - funct3 not in {000,001,010,100,101}
  - store with funct3 100/101
  - H with addr[0]=1
  - W with addr[1:0]!=0
  - word index >= DEPTH_WORDS
- FSM states: IDLE, LOAD, RMW_RD, WRITE, RESP.
- IDLE -> transition on acceptance:
  - error -> RESP
  - load -> LOAD
  - SW -> WRITE
  - SB/SH -> RMW_RD
- LOAD: mem_read=1 for one cycle, then -> RESP.
  - Byte lane is selected by addr[1:0]; halfword lane by addr[1].
  - B/H results are sign-extended; BU/HU results are zero-extended; W passes through.
  - The result is registered into resp_rdata.
- RMW_RD: mem_read=1 for one cycle and mem_rdata is captured into a merge register, then -> WRITE.
- WRITE: mem_write=1 for exactly one cycle, then -> RESP.
  - SW writes req_wdata.
  - SB replaces byte lane addr[1:0] with wdata[7:0].
  - SH replaces half lane addr[1] with wdata[15:0].
  - All other bits come from the merge register.
- RESP: resp_valid=1, held with stable resp_rdata/resp_err until resp_ready=1; then -> IDLE.
  - resp_ready=0 stalls indefinitely.
  - No new request is accepted until IDLE.
- mem_addr holds the registered address in LOAD, RMW_RD and WRITE, and is 0 otherwise.
- mem_read and mem_write are never both 1. Both are 0 in IDLE and RESP.
- Latency from acceptance edge to resp_valid rising, with resp_ready=1:
  - error: 1 cycle
  - load: 2 cycles
  - SW: 2 cycles
  - SB/SH: 3 cycles
- Back-to-back throughput: the next request is accepted in the cycle after the RESP handshake.
- Address wrap: none; out-of-range is reported as an error, never truncated.

Test Plan:
- Store then load word: SW 0xDEADBEEF to 0x10, then LW 0x10 -> one mem_write pulse with mem_addr=4, mem_wdata=0xDEADBEEF; load resp_rdata=0xDEADBEEF, resp_err=0, each response 2 cycles after acceptance.
- Read-modify-write of a byte: memory word 4 = 0x11223344; SB 0xAA to 0x12 -> RMW_RD read then mem_wdata=0x11AA3344; LB 0x12 -> 0xFFFFFFAA; LBU 0x12 -> 0x000000AA.
- Halfword store: SH 0x8001 to 0x16 over 0x11223344 -> 0x80013344; LH 0x16 -> 0xFFFF8001; LHU -> 0x00008001.
- Errors: LW 0x11, SH 0x13, funct3=011, SBU (we=1, funct3=100), and LW 0x1000 with DEPTH_WORDS=1024 -> each gives resp_err=1, resp_rdata=0, 1-cycle latency, and mem_read/mem_write stay 0 throughout.
- Response backpressure: LW held in RESP with resp_ready=0 for 5 cycles -> resp_valid and resp_rdata stable, req_ready=0; resp_ready=1 then returns to IDLE with req_ready=1 on the next cycle.
- Reset mid-RMW: assert rst_n=0 during RMW_RD of an SB -> outputs go to 0 immediately, no mem_write pulse ever occurs, the memory word is unchanged, and req_ready=1 after release.
